mmio_access_monitor: RTL and testbench

- Parametrised, multi-channel memory-mapped I/O access monitor. It sits on the processor data-memory address path, between the core and the data memory/IO bus.
- It watches for accesses to per-channel device data addresses. On a hit it redirects the outgoing address to the shared status address for a programmable number of cycles and reports which channel fired.
- Hits arriving while a redirect is in progress are queued per channel and serviced lowest-index-first. A sticky overflow flag records lost hits.

---
 rtl/mmio_access_monitor.sv | 64 ++++++
 tb/tb_mmio_access_monitor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mmio_access_monitor.sv
// mmio_access_monitor: redirects device data-address hits to a shared status address, queuing per-channel hits
module mmio_access_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_CHANNELS = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hFFFF8000,
  parameter int DATA_STRIDE = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int CH_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  input  logic                    clr_overflow,
  output logic [ADDR_WIDTH-1:0]   out_address,
  output logic                    status,
  output logic [CH_W-1:0]         status_channel,
  output logic [NUM_CHANNELS-1:0] pending,
  output logic                    overflow
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [NUM_CHANNELS-1:0] hit, req, oh;
  logic [CH_W-1:0] sel;
  logic ovf_evt;
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_hit
    localparam logic [ADDR_WIDTH-1:0] DA = BASE_ADDR + ADDR_WIDTH'(DATA_STRIDE * (k + 1));
    assign hit[k] = in_valid && (in_address == DA);
  end
  assign req = pending | hit;
  assign oh = NUM_CHANNELS'(1) << sel;
  assign ovf_evt = (state == REDIRECT) && |(pending & hit);
  assign status = state == REDIRECT;
  assign out_address = status ? BASE_ADDR : in_address;
  always_comb begin
    sel = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (req[i]) sel = CH_W'(i);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      pending <= '0;
      overflow <= 1'b0;
      status_channel <= '0;
    end else begin
      overflow <= ovf_evt | (overflow & ~clr_overflow);
      if (state == IDLE || cnt == '0) begin
        state <= |req ? REDIRECT : IDLE;
        pending <= req & ~oh;
        if (|req) begin
          status_channel <= sel;
          cnt <= CW'(HOLD_CYCLES - 1);
        end
      end else begin
        cnt <= cnt - CW'(1);
        pending <= req;
      end
    end
  end
endmodule

// File: tb/tb_mmio_access_monitor.sv
// tb_mmio_access_monitor: three differently parameterised monitors driven randomly and checked against a redirect-window model
module tb_mmio_access_monitor;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic v[3];
  logic [31:0] a[3];
  logic c[3];
  logic [31:0] oa[3];
  logic st[3];
  logic [3:0] ch[3];
  logic ov[3];
  logic [3:0] pd0, pd1;
  logic [7:0] pd2;
  logic [7:0] pd[3];
  assign pd[0] = {4'h0, pd0};
  assign pd[1] = {4'h0, pd1};
  assign pd[2] = pd2;
  int n_tests = 0;
  int n_fail = 0;
  int nch[3] = '{4, 4, 8};
  int hold[3] = '{1, 4, 3};
  int stride[3] = '{4, 4, 16};
  logic [31:0] base[3] = '{32'hFFFF8000, 32'hFFFF8000, 32'h80000000};
  int busy[3];
  int cur[3];
  bit pend[3][8];
  bit movf[3];

  mmio_access_monitor #(.HOLD_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_address(a[0]), .clr_overflow(c[0]),
    .out_address(oa[0]), .status(st[0]), .status_channel(ch[0]), .pending(pd0), .overflow(ov[0]));
  mmio_access_monitor #(.HOLD_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_address(a[1]), .clr_overflow(c[1]),
    .out_address(oa[1]), .status(st[1]), .status_channel(ch[1]), .pending(pd1), .overflow(ov[1]));
  mmio_access_monitor #(.NUM_CHANNELS(8), .DATA_STRIDE(16), .BASE_ADDR(32'h80000000), .HOLD_CYCLES(3)) u2 (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_address(a[2]), .clr_overflow(c[2]),
    .out_address(oa[2]), .status(st[2]), .status_channel(ch[2]), .pending(pd2), .overflow(ov[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] daddr(input int i, input int k);
    return base[i] + 32'(stride[i] * (k + 1));
  endfunction

  function automatic logic [31:0] pk(input int i);
    logic [31:0] r = '0;
    for (int k = 0; k < 8; k++) r[k] = pend[i][k];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      busy[i] = 0;
      cur[i] = 0;
      movf[i] = 0;
      for (int k = 0; k < 8; k++) pend[i][k] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit h[8];
    bit ev = 0;
    bit found = 0;
    for (int k = 0; k < 8; k++) h[k] = k < nch[i] && v[i] && a[i] == daddr(i, k);
    for (int k = 0; k < 8; k++) begin
      if (busy[i] > 0 && pend[i][k] && h[k]) ev = 1;
      pend[i][k] = pend[i][k] | h[k];
    end
    movf[i] = ev || (movf[i] && !c[i]);
    if (busy[i] > 0) busy[i]--;
    if (busy[i] == 0)
      for (int k = 0; k < 8; k++)
        if (!found && pend[i][k]) begin
          found = 1;
          pend[i][k] = 0;
          cur[i] = k;
          busy[i] = hold[i];
        end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.status", i), 32'(st[i]), 32'(busy[i] > 0));
      chk($sformatf("u%0d.out_address", i), oa[i], busy[i] > 0 ? base[i] : a[i]);
      if (busy[i] > 0) chk($sformatf("u%0d.status_channel", i), 32'(ch[i]), 32'(cur[i]));
      chk($sformatf("u%0d.pending", i), 32'(pd[i]), pk(i));
      chk($sformatf("u%0d.overflow", i), 32'(ov[i]), 32'(movf[i]));
    end
  endtask

  task automatic drive(input int dens);
    for (int i = 0; i < 3; i++) begin
      int r = $urandom_range(0, 9);
      v[i] = $urandom_range(0, 7) != 0;
      c[i] = $urandom_range(0, 9) == 0;
      if (r < dens) a[i] = daddr(i, $urandom_range(0, nch[i] - 1));
      else begin
        case ($urandom_range(0, 3))
          0: a[i] = daddr(i, nch[i]);
          1: a[i] = base[i];
          2: a[i] = daddr(i, $urandom_range(0, nch[i] - 1)) + 32'(stride[i] / 2);
          default: a[i] = $urandom;
        endcase
      end
    end
  endtask

  initial begin
    int dens = 5;
    model_reset();
    drive(dens);
    #1 check_all();
    #2 reset = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      @(negedge clk);
      check_all();
      if (cyc % 100 == 0) dens = $urandom_range(0, 9);
      drive(dens);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
